uart_rx: RTL and testbench

- UART receiver: the receive-side counterpart of the existing UART transmit path, on the same frame format.
- Frame: start bit 0, P_DATA_WIDTH data bits LSB first, optional parity bit, one stop bit 1.
- Oversamples RX_IN at Prescale ticks per bit, takes a 3-sample majority vote mid-bit, and delivers the parallel word with a one-cycle Data_Valid strobe.
- Sits at the serial input of the system, feeding the register/command layer.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_sampler.sv | 66 ++++++
 rtl/uart_rx.sv | 141 ++++++++++++++
 tb/tb_uart_rx.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, legal
// oversampling ratios and parity-type codes.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    // Oversampling ratios the receiver understands; anything else runs as 8.
    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

    // Internal width of the latched ratio and the in-bit edge counter.
    localparam int PRESC_CNT_W = 6;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit timing for the receiver: edge/bit counters over the latched ratio,
// three mid-bit samples and their majority vote.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int BIT_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
    input  logic                   rx_in,
    input  logic [PRESC_CNT_W-1:0] presc,
    output logic [BIT_W-1:0]       bit_cnt,
    output logic                   bit_end,
    output logic                   sample_done,
    output logic                   sampled_bit
);

    logic [PRESC_CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [PRESC_CNT_W-1:0] half;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [2:0]             smp_q, smp_d;

    assign half        = presc >> 1;
    assign bit_end     = run && (edge_cnt_q == presc - PRESC_CNT_W'(1));
    // Decision point: the third sample was captured on the previous edge.
    assign sample_done = run && (edge_cnt_q == half + PRESC_CNT_W'(2));
    assign sampled_bit = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) |
                         (smp_q[1] & smp_q[2]);
    assign bit_cnt     = bit_cnt_q;

    // Counters advance only while a frame is in progress; samples straddle mid-bit.
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        smp_d      = smp_q;
        if (!run) begin
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
        end else begin
            if (bit_end) begin
                edge_cnt_d = '0;
                bit_cnt_d  = bit_cnt_q + BIT_W'(1);
            end else begin
                edge_cnt_d = edge_cnt_q + PRESC_CNT_W'(1);
            end
            if (edge_cnt_q == half - PRESC_CNT_W'(1)) smp_d[0] = rx_in;
            if (edge_cnt_q == half)                   smp_d[1] = rx_in;
            if (edge_cnt_q == half + PRESC_CNT_W'(1)) smp_d[2] = rx_in;
        end
    end

    // Counter and sample registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            smp_q      <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            smp_q      <= smp_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start detect, LSB-first deserialiser, optional parity and
// stop check, with one-cycle Data_Valid / par_err / stp_err strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int P_DATA_WIDTH   = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    output logic [P_DATA_WIDTH-1:0]   P_DATA,
    output logic                      Data_Valid,
    output logic                      par_err,
    output logic                      stp_err
);

    localparam int BIT_W = $clog2(P_DATA_WIDTH + 3);

    rx_state_e                state_q, state_d;
    logic [P_DATA_WIDTH-1:0]  shift_q, shift_d;
    logic [P_DATA_WIDTH-1:0]  p_data_q, p_data_d;
    logic [PRESC_CNT_W-1:0]   presc_q, presc_d, presc_sel;
    logic                     par_en_q, par_en_d;
    logic                     par_typ_q, par_typ_d;
    logic                     par_flag_q, par_flag_d;
    logic                     dv_q, dv_d, pe_q, pe_d, se_q, se_d;

    logic [BIT_W-1:0]         bit_cnt;
    logic                     bit_end, sample_done, sampled_bit;

    uart_rx_sampler #(.BIT_W(BIT_W)) u_sampler (
        .clk         (CLK),
        .rst_n       (RST),
        .run         (state_q != IDLE),
        .rx_in       (RX_IN),
        .presc       (presc_q),
        .bit_cnt     (bit_cnt),
        .bit_end     (bit_end),
        .sample_done (sample_done),
        .sampled_bit (sampled_bit)
    );

    // Map the requested ratio onto a legal one; unknown values fall back to 8.
    always_comb begin
        presc_sel = PRESC_CNT_W'(PRESCALE_8);
        if (Prescale == PRESCALE_WIDTH'(PRESCALE_16))
            presc_sel = PRESC_CNT_W'(PRESCALE_16);
        else if (Prescale == PRESCALE_WIDTH'(PRESCALE_32))
            presc_sel = PRESC_CNT_W'(PRESCALE_32);
    end

    // Frame FSM: next state, deserialiser, parity tracking and strobes.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        p_data_d   = p_data_q;
        presc_d    = presc_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        par_flag_d = par_flag_q;
        dv_d       = 1'b0;
        pe_d       = 1'b0;
        se_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!RX_IN) begin
                    state_d    = START;
                    presc_d    = presc_sel;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    par_flag_d = 1'b0;
                end
            end
            START: begin
                // A high majority means the falling edge was noise.
                if (sample_done && sampled_bit) state_d = IDLE;
                else if (bit_end)               state_d = DATA;
            end
            DATA: begin
                if (sample_done) shift_d = {sampled_bit, shift_q[P_DATA_WIDTH-1:1]};
                if (bit_end && (bit_cnt == BIT_W'(P_DATA_WIDTH)))
                    state_d = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                if (sample_done && (sampled_bit != (^shift_q ^ par_typ_q)))
                    par_flag_d = 1'b1;
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                // Leave at mid-bit so a back-to-back start edge is not missed.
                if (sample_done) begin
                    state_d = IDLE;
                    if (!sampled_bit)    se_d = 1'b1;
                    else if (par_flag_q) pe_d = 1'b1;
                    else begin
                        dv_d     = 1'b1;
                        p_data_d = shift_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, configuration and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            p_data_q   <= '0;
            presc_q    <= PRESC_CNT_W'(PRESCALE_8);
            par_en_q   <= 1'b0;
            par_typ_q  <= PAR_EVEN;
            par_flag_q <= 1'b0;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            se_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            p_data_q   <= p_data_d;
            presc_q    <= presc_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            par_flag_q <= par_flag_d;
            dv_q       <= dv_d;
            pe_q       <= pe_d;
            se_q       <= se_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign Data_Valid = dv_q;
    assign par_err    = pe_q;
    assign stp_err    = se_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven bit by bit on the falling
// clock edge, strobes are tallied by a monitor, checks are immediate asserts.
module tb_uart_rx;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       par_err;
    logic       stp_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int dv_n = 0, pe_n = 0, se_n = 0, multi_n = 0, dv_cyc = 0;
    int d0, p0, s0, t0;
    logic [7:0] pd;

    uart_rx #(.P_DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .Prescale   (Prescale),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .par_err    (par_err),
        .stp_err    (stp_err)
    );

    always #5 CLK = ~CLK;

    // Rising-edge count used for latency measurement.
    always @(posedge CLK) cyc++;

    // Tally strobe cycles away from the active edge.
    always @(negedge CLK) begin
        if (Data_Valid) begin
            dv_n++;
            dv_cyc = cyc;
        end
        if (par_err) pe_n++;
        if (stp_err) se_n++;
        if (int'(Data_Valid) + int'(par_err) + int'(stp_err) > 1) multi_n++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b, input int n);
        RX_IN = b;
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [7:0] d, input int p, input logic pen,
                              input logic pbit, input logic sbit);
        drive_bit(1'b0, p);
        for (int i = 0; i < 8; i++) drive_bit(d[i], p);
        if (pen) drive_bit(pbit, p);
        drive_bit(sbit, p);
        RX_IN = 1'b1;
    endtask

    task automatic snap();
        d0 = dv_n;
        p0 = pe_n;
        s0 = se_n;
    endtask

    initial begin
        RST = 1'b0; RX_IN = 1'b1; Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_pdata", P_DATA, 0);
        chk("rst_dv", Data_Valid, 0);
        chk("rst_pe", par_err, 0);
        chk("rst_se", stp_err, 0);
        RST = 1'b1;
        repeat (4) @(negedge CLK);

        // 0xA5, even parity bit 0, ratio 8
        Prescale = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0;
        snap(); t0 = cyc;
        send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1);
        repeat (4) @(negedge CLK);
        chk("a5_dv_cnt", dv_n - d0, 1);
        chk("a5_pdata", P_DATA, 8'hA5);
        chk("a5_pe_cnt", pe_n - p0, 0);
        chk("a5_se_cnt", se_n - s0, 0);
        chk("a5_latency", dv_cyc - t0 - 1, 87);

        // 0x3C, odd parity expects 1, send 0
        Prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b1;
        snap();
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1);
        repeat (4) @(negedge CLK);
        chk("3c_pe_cnt", pe_n - p0, 1);
        chk("3c_dv_cnt", dv_n - d0, 0);
        chk("3c_pdata_held", P_DATA, 8'hA5);

        // 0x81 with a bad stop bit, then 0x7E, ratio 32, no parity
        Prescale = 6'd32; PAR_EN = 1'b0;
        snap();
        send_frame(8'h81, 32, 1'b0, 1'b0, 1'b0);
        repeat (64) @(negedge CLK);
        chk("81_se_cnt", se_n - s0, 1);
        chk("81_dv_cnt", dv_n - d0, 0);
        snap();
        send_frame(8'h7E, 32, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge CLK);
        chk("7e_dv_cnt", dv_n - d0, 1);
        chk("7e_pdata", P_DATA, 8'h7E);

        // 3-cycle glitch is rejected silently, then 0x55
        Prescale = 6'd8;
        snap();
        drive_bit(1'b0, 3);
        drive_bit(1'b1, 20);
        chk("glitch_strobes", (dv_n - d0) + (pe_n - p0) + (se_n - s0), 0);
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge CLK);
        chk("55_dv_cnt", dv_n - d0, 1);
        chk("55_pdata", P_DATA, 8'h55);

        // back-to-back 0x12, 0x34 at ratio 16
        Prescale = 6'd16;
        snap();
        send_frame(8'h12, 16, 1'b0, 1'b0, 1'b1);
        chk("12_pdata", P_DATA, 8'h12);
        send_frame(8'h34, 16, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge CLK);
        chk("b2b_dv_cnt", dv_n - d0, 2);
        chk("34_pdata", P_DATA, 8'h34);

        // reset in the middle of data bit 4
        snap();
        pd = 8'hA5;
        drive_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) drive_bit(pd[i], 16);
        drive_bit(pd[4], 8);
        RST = 1'b0; RX_IN = 1'b1;
        @(negedge CLK);
        chk("mid_rst_pdata", P_DATA, 0);
        chk("mid_rst_dv", Data_Valid, 0);
        chk("mid_rst_pe", par_err, 0);
        chk("mid_rst_se", stp_err, 0);
        RST = 1'b1;
        repeat (40) @(negedge CLK);
        chk("mid_rst_strobes", (dv_n - d0) + (pe_n - p0) + (se_n - s0), 0);
        send_frame(8'hFF, 16, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge CLK);
        chk("ff_dv_cnt", dv_n - d0, 1);
        chk("ff_pdata", P_DATA, 8'hFF);

        // line stuck low for a full frame; next start lands on the strobe cycle
        Prescale = 6'd8; PAR_EN = 1'b0;
        snap();
        drive_bit(1'b0, 80);
        t0 = cyc;
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge CLK);
        chk("stuck_se_cnt", se_n - s0, 1);
        chk("5a_dv_cnt", dv_n - d0, 1);
        chk("5a_pdata", P_DATA, 8'h5A);
        chk("5a_latency", dv_cyc - t0 - 1, 79);

        chk("strobe_overlap", multi_n, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
